// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/data) arbiter for a shared single-port memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_xfer,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_xfer,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             owner_d;
    logic             we_q;
    logic [CNT_W-1:0] lat_cnt;
    logic [SC_W-1:0]  starve_cnt;

    logic             if_elig;
    logic             d_elig;
    logic             grant;
    logic             grant_d;
    logic             lat_last;

    // The requester finishing in DONE has its request treated as consumed.
    always_comb begin
        if_elig  = if_req && !(state == DONE && !owner_d);
        d_elig   = d_req && !(state == DONE && owner_d);
        grant    = (state == IDLE || state == DONE) && (if_elig || d_elig);
        grant_d  = d_elig && !(if_elig && starve_cnt == SC_W'(STARVE_MAX));
        lat_last = (lat_cnt == CNT_W'(LAT - 1));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = STROBE;
            STROBE:  state_nx = we_q ? DONE : WAIT;
            WAIT:    if (lat_last) state_nx = DONE;
            DONE:    state_nx = grant ? STROBE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            we_q       <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_xfer   <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner_d <= grant_d;
                if (grant_d) begin
                    we_q      <= d_write;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_xfer  <= d_xfer;
                    if (!if_elig)
                        starve_cnt <= '0;
                    else if (starve_cnt != SC_W'(STARVE_MAX))
                        starve_cnt <= starve_cnt + SC_W'(1);
                end else begin
                    we_q       <= 1'b0;
                    mem_addr   <= if_addr;
                    mem_wdata  <= '0;
                    mem_xfer   <= 4'b1000;
                    starve_cnt <= '0;
                end
            end
            if (state == STROBE)
                lat_cnt <= '0;
            else if (state == WAIT)
                lat_cnt <= lat_cnt + CNT_W'(1);
            // Read data lands at the end of the last WAIT cycle, ahead of the valid pulse.
            if (state == WAIT && lat_last) begin
                if (owner_d)
                    d_rdata <= mem_rdata;
                else
                    if_rdata <= mem_rdata[31:0];
            end
        end
    end

    assign mem_en     = (state == STROBE);
    assign mem_we     = (state == STROBE) && we_q;
    assign if_valid   = (state == DONE) && !owner_d;
    assign d_valid    = (state == DONE) && owner_d;
    assign pipe_stall = (if_req & ~if_valid) | (d_req & ~d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench against a transaction-schedule model
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;
    localparam int NCYC       = 4000;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_xfer;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_xfer;
    logic [DATA_W-1:0] mem_rdata;
    logic              pipe_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LAT       (LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_xfer    (d_xfer),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_xfer  (mem_xfer),
        .mem_rdata (mem_rdata),
        .pipe_stall(pipe_stall)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: one transaction at a time, described by its strobe and completion cycles.
    bit          m_busy, m_own_d, m_read, m_we;
    int          m_strobe, m_done, starve;
    logic [63:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
    logic [3:0]  e_xfer;
    bit          prev_ifv, prev_dv;
    bit          exp_ifv, exp_dv, exp_en;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit completing, ie, de, pick_d;
        if (rst) begin
            m_busy     = 0;
            e_addr     = '0;
            e_wdata    = '0;
            e_xfer     = '0;
            e_if_rdata = '0;
            e_d_rdata  = '0;
            starve     = 0;
        end else begin
            completing = m_busy && (cyc == m_done);
            if (m_busy && m_read && cyc == m_strobe + LAT) begin
                if (m_own_d) e_d_rdata = mem_rdata;
                else         e_if_rdata = {32'b0, mem_rdata[31:0]};
            end
            if (!m_busy || completing) begin
                ie     = if_req && !(completing && !m_own_d);
                de     = d_req && !(completing && m_own_d);
                m_busy = ie || de;
                if (m_busy) begin
                    pick_d   = de && !(ie && starve == STARVE_MAX);
                    m_own_d  = pick_d;
                    m_strobe = cyc + 1;
                    if (pick_d) begin
                        m_we    = d_write;
                        m_read  = !d_write;
                        e_addr  = d_addr;
                        e_wdata = d_wdata;
                        e_xfer  = d_xfer;
                        starve  = ie ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
                    end else begin
                        m_we    = 0;
                        m_read  = 1;
                        e_addr  = if_addr;
                        e_wdata = '0;
                        e_xfer  = 4'b1000;
                        starve  = 0;
                    end
                    m_done = m_read ? cyc + 2 + LAT : cyc + 2;
                end
            end
        end
    endtask

    initial begin
        logic [3:0] xfers [4];
        xfers[0] = 4'b1000; xfers[1] = 4'b0001; xfers[2] = 4'b0010; xfers[3] = 4'b0100;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; d_xfer = '0; mem_rdata = '0;
        prev_ifv = 0; prev_dv = 0; m_busy = 0;
        repeat (2) @(posedge clk);
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            model_edge();
            cyc++;
            if (if_req && prev_ifv)
                if_req = 1'b0;
            else if (!if_req && $urandom_range(2) == 0) begin
                if_req  = 1'b1;
                if_addr = {$urandom, $urandom};
            end
            if (d_req && prev_dv)
                d_req = 1'b0;
            else if (!d_req && $urandom_range(2) == 0) begin
                d_req   = 1'b1;
                d_write = ($urandom_range(1) == 1);
                d_addr  = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_xfer  = xfers[$urandom_range(3)];
            end
            mem_rdata = {$urandom, $urandom};
            rst = ($urandom_range(59) == 0);
            #2;
            exp_en  = m_busy && cyc == m_strobe;
            exp_ifv = m_busy && cyc == m_done && !m_own_d;
            exp_dv  = m_busy && cyc == m_done && m_own_d;
            check("mem_en",     {63'b0, mem_en},     {63'b0, exp_en});
            check("mem_we",     {63'b0, mem_we},     {63'b0, exp_en && m_we});
            check("mem_addr",   mem_addr,            e_addr);
            check("mem_wdata",  mem_wdata,           e_wdata);
            check("mem_xfer",   {60'b0, mem_xfer},   {60'b0, e_xfer});
            check("if_valid",   {63'b0, if_valid},   {63'b0, exp_ifv});
            check("d_valid",    {63'b0, d_valid},    {63'b0, exp_dv});
            check("if_rdata",   {32'b0, if_rdata},   e_if_rdata);
            check("d_rdata",    d_rdata,             e_d_rdata);
            check("pipe_stall", {63'b0, pipe_stall},
                  {63'b0, (if_req && !exp_ifv) || (d_req && !exp_dv)});
            prev_ifv = exp_ifv;
            prev_dv  = exp_dv;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
